// File: rtl/align_pkg.sv
// align_pkg: shared constants and helpers for the block aligner pipeline
package align_pkg;
  localparam logic [31:0] EXP_SPECIAL = '1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int out_w(input int x_width, input int m_width, input int guard_width);
    return 2 + x_width + m_width + guard_width;
  endfunction
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/align_pipe_if.sv
// align_pipe_if: upstream and downstream valid/ready beat bus of the aligner
interface align_pipe_if
  import align_pkg::*;
#(
  parameter int N = 16,
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int GUARD_WIDTH = 3
);
  localparam int OUT_W = out_w(clog2(N), M_WIDTH, GUARD_WIDTH);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] s_i;
  logic [E_WIDTH*N-1:0] e_i;
  logic [M_WIDTH*N-1:0] m_i;
  logic out_valid;
  logic out_ready;
  logic [E_WIDTH-1:0] e_o;
  logic [OUT_W*N-1:0] m_o;
  logic special_o;
  modport slave (
    input in_valid, s_i, e_i, m_i, out_ready,
    output in_ready, out_valid, e_o, m_o, special_o
  );
  modport master (
    output in_valid, s_i, e_i, m_i, out_ready,
    input in_ready, out_valid, e_o, m_o, special_o
  );
endinterface

// File: rtl/align_pipe_max_tree.sv
// max_tree: combinational max over the enabled lanes of a packed exponent vector
module max_tree
  import align_pkg::*;
#(
  parameter int N = 16,
  parameter int E_WIDTH = 8
) (
  input  logic [E_WIDTH*N-1:0] e_i,
  input  logic [N-1:0]         en_i,
  output logic [E_WIDTH-1:0]   max_o
);
  always_comb begin
    max_o = '0;
    for (int i = 0; i < N; i++)
      max_o = (en_i[i] && e_i[lane_lo(i, E_WIDTH) +: E_WIDTH] > max_o) ? e_i[lane_lo(i, E_WIDTH) +: E_WIDTH] : max_o;
  end
endmodule

// File: rtl/align_pipe.sv
// align_pipe: 3-stage back-pressurable block-exponent aligner
module align_pipe
  import align_pkg::*;
#(
  parameter int N = 16,
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int GUARD_WIDTH = 3,
  parameter int X_WIDTH = clog2(N),
  parameter int OUT_W = out_w(X_WIDTH, M_WIDTH, GUARD_WIDTH)
) (
  input logic        clock,
  input logic        reset,
  align_pipe_if.slave bus
);
  localparam int MW = M_WIDTH + GUARD_WIDTH + 1;
  localparam logic [E_WIDTH-1:0] ESPEC = EXP_SPECIAL[E_WIDTH-1:0];
  logic rdy1, rdy2, rdy3;
  logic v1_q, v2_q, v3_q;
  logic [N-1:0] s1_q, s2_q, ok_d;
  logic [E_WIDTH*N-1:0] e1_q;
  logic [M_WIDTH*N-1:0] m1_q;
  logic [E_WIDTH-1:0] emax_d, emax1_q, emax2_q, e3_q;
  logic sp1_q, sp2_q, sp3_q;
  logic [MW*N-1:0] mag_d, mag2_q;
  logic [OUT_W*N-1:0] m3_d, m3_q;
  assign rdy3 = !v3_q || bus.out_ready;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;
  assign bus.in_ready = rdy1;
  assign bus.out_valid = v3_q;
  assign bus.e_o = e3_q;
  assign bus.m_o = m3_q;
  assign bus.special_o = sp3_q;
  max_tree #(.N(N), .E_WIDTH(E_WIDTH)) u_max (.e_i(bus.e_i), .en_i(ok_d), .max_o(emax_d));
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [E_WIDTH-1:0] e1, d;
    logic h, sat;
    logic [MW-1:0] mag;
    logic [2*MW-1:0] ext;
    assign ok_d[g] = bus.e_i[lane_lo(g, E_WIDTH) +: E_WIDTH] != ESPEC;
    assign e1 = e1_q[lane_lo(g, E_WIDTH) +: E_WIDTH];
    assign h = e1 != '0;
    assign d = emax1_q - e1;
    assign sat = 32'(d) >= MW;
    assign mag = h ? {1'b1, m1_q[lane_lo(g, M_WIDTH) +: M_WIDTH], GUARD_WIDTH'(0)} : '0;
    // low half of ext holds everything shifted out, folded into the sticky LSB
    assign ext = {mag, MW'(0)} >> d;
    assign mag_d[lane_lo(g, MW) +: MW] = (e1 == ESPEC) ? '0 : sat ? MW'(h) : ext[2*MW-1:MW] | MW'(|ext[MW-1:0]);
    assign m3_d[lane_lo(g, OUT_W) +: OUT_W] = s2_q[g] ? -OUT_W'(mag2_q[lane_lo(g, MW) +: MW]) : OUT_W'(mag2_q[lane_lo(g, MW) +: MW]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      e3_q <= '0;
      m3_q <= '0;
      sp3_q <= 1'b0;
    end else begin
      if (rdy1) v1_q <= bus.in_valid;
      if (rdy2) v2_q <= v1_q;
      if (rdy3) v3_q <= v2_q;
      if (rdy1 && bus.in_valid) begin
        s1_q <= bus.s_i;
        e1_q <= bus.e_i;
        m1_q <= bus.m_i;
        emax1_q <= emax_d;
        sp1_q <= |(~ok_d);
      end
      if (rdy2 && v1_q) begin
        s2_q <= s1_q;
        mag2_q <= mag_d;
        emax2_q <= emax1_q;
        sp2_q <= sp1_q;
      end
      if (rdy3 && v2_q) begin
        e3_q <= emax2_q;
        m3_q <= m3_d;
        sp3_q <= sp2_q;
      end
    end
  end
endmodule

// File: tb/tb_align_pipe.sv
// tb_align_pipe: directed vectors, flow-control sequences and a scoreboarded random run for N=4
module tb_align_pipe;
  typedef struct packed {
    logic [7:0]   xe;
    logic [119:0] xm;
    logic         xs;
  } exp_t;
  typedef struct {
    logic [3:0]   s;
    logic [31:0]  e;
    logic [91:0]  m;
    logic [7:0]   xe;
    logic [119:0] xm;
    logic         xs;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  align_pipe_if #(.N(4), .E_WIDTH(8), .M_WIDTH(23), .GUARD_WIDTH(3)) bus ();
  align_pipe #(.N(4), .E_WIDTH(8), .M_WIDTH(23), .GUARD_WIDTH(3)) dut (.clock(clk), .reset(rst), .bus(bus));
  vec_t vt[6];
  exp_t q[$];
  exp_t x;
  int n_chk = 0, n_pass = 0, n_in = 0, n_out = 0;
  int lat, cyc, b_in, b_out, seen, k;
  logic pend_hold = 1'b0;
  logic [7:0] h_e;
  logic [119:0] h_m;
  logic h_s;
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] e, input logic [91:0] m);
    exp_t r;
    logic [7:0] mx, ei;
    logic [63:0] mag, v;
    int d;
    mx = 8'd0;
    r.xs = 1'b0;
    r.xm = '0;
    for (int i = 0; i < 4; i++) begin
      ei = e[i*8 +: 8];
      if (ei == 8'hFF) r.xs = 1'b1;
      else if (ei > mx) mx = ei;
    end
    r.xe = mx;
    for (int i = 0; i < 4; i++) begin
      ei = e[i*8 +: 8];
      if (ei != 8'h00 && ei != 8'hFF) begin
        mag = (64'd1 << 26) | (64'(m[i*23 +: 23]) << 3);
        d = int'(mx) - int'(ei);
        if (d >= 27) v = 64'd1;
        else begin
          v = mag >> d;
          if ((mag & ((64'd1 << d) - 64'd1)) != 64'd0) v = v | 64'd1;
        end
        if (s[i]) v = (64'd1 << 30) - v;
        r.xm[i*30 +: 30] = v[29:0];
      end
    end
    return r;
  endfunction
  task automatic set_vec(input int i, input logic [3:0] s, input logic [31:0] e, input logic [91:0] m,
                         input logic [7:0] xe, input logic [119:0] xm, input logic xs);
    vt[i].s = s; vt[i].e = e; vt[i].m = m; vt[i].xe = xe; vt[i].xm = xm; vt[i].xs = xs;
  endtask
  // called just after inputs are driven on a falling edge; samples handshakes, then moves to the next falling edge
  task automatic step();
    #1;
    if (pend_hold)
      chk("hold_stable", 160'({bus.out_valid, bus.e_o, bus.m_o, bus.special_o}), 160'({1'b1, h_e, h_m, h_s}));
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(model(bus.s_i, bus.e_i, bus.m_i));
      n_in++;
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_expected_beat", 160'(q.size() != 0), 160'(1));
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("sb_beat", 160'({bus.e_o, bus.m_o, bus.special_o}), 160'({x.xe, x.xm, x.xs}));
      end
      n_out++;
    end
    pend_hold = bus.out_valid && !bus.out_ready;
    h_e = bus.e_o;
    h_m = bus.m_o;
    h_s = bus.special_o;
    @(negedge clk);
  endtask
  task automatic drive_seq(input int i);
    bus.in_valid = 1'b1;
    bus.s_i = 4'(i);
    bus.e_i = {4{8'(20 + i)}} - 32'h00010203;
    bus.m_i = {4{23'(i * 7 + 1)}};
  endtask
  task automatic rand_beat();
    logic [7:0] base, ev;
    int r;
    base = 8'($urandom_range(1, 254));
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 15);
      ev = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 :
           (r < 10) ? ((base > 8'd40) ? base - 8'($urandom_range(0, 40)) : base) : 8'($urandom_range(1, 254));
      bus.e_i[i*8 +: 8] = ev;
      bus.s_i[i] = 1'($urandom_range(0, 1));
      bus.m_i[i*23 +: 23] = 23'($urandom);
    end
  endtask
  initial begin
    set_vec(0, 4'b0010, {8'd127, 8'd0, 8'd128, 8'd130}, 92'd0, 8'd130,
            {30'h0800000, 30'h0, 30'h3F000000, 30'h4000000}, 1'b0);
    set_vec(1, 4'b0000, {8'd0, 8'd0, 8'd103, 8'd130}, {23'd0, 23'd0, 23'd1, 23'd0}, 8'd130,
            {30'h0, 30'h0, 30'h1, 30'h4000000}, 1'b0);
    set_vec(2, 4'b0100, {8'd0, 8'd1, 8'd1, 8'd254}, 92'd0, 8'd254,
            {30'h0, 30'h3FFFFFFF, 30'h1, 30'h4000000}, 1'b0);
    set_vec(3, 4'b1001, {8'd0, 8'd90, 8'd100, 8'd255}, {23'h7FFFFF, 23'd5, 23'd0, 23'd1}, 8'd100,
            {30'h0, 30'h10001, 30'h4000000, 30'h0}, 1'b1);
    set_vec(4, 4'b1111, {8'd0, 8'd255, 8'd0, 8'd255}, {4{23'h5A5A5}}, 8'd0, 120'd0, 1'b1);
    set_vec(5, 4'b0010, {8'd128, 8'd129, 8'd130, 8'd131}, {23'd1, 23'd1, 23'h7FFFFF, 23'h7FFFFF}, 8'd131,
            {30'h800001, 30'h1000002, 30'h3C000004, 30'h7FFFFF8}, 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.s_i = '0;
    bus.e_i = '0;
    bus.m_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 160'(bus.out_valid), 160'(0));
    chk("rst_e_o", 160'(bus.e_o), 160'(0));
    chk("rst_m_o", 160'(bus.m_o), 160'(0));
    chk("rst_special_o", 160'(bus.special_o), 160'(0));
    rst = 1'b0;
    #1 chk("rst_in_ready", 160'(bus.in_ready), 160'(1));
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      bus.in_valid = 1'b1;
      bus.s_i = vt[v].s;
      bus.e_i = vt[v].e;
      bus.m_i = vt[v].m;
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 8) begin
        step();
        lat++;
      end
      chk($sformatf("v%0d_latency", v), 160'(lat), 160'(3));
      chk($sformatf("v%0d_e_o", v), 160'(bus.e_o), 160'(vt[v].xe));
      chk($sformatf("v%0d_m_o", v), 160'(bus.m_o), 160'(vt[v].xm));
      chk($sformatf("v%0d_special_o", v), 160'(bus.special_o), 160'(vt[v].xs));
      step();
    end
    bus.out_ready = 1'b0;
    b_in = n_in;
    b_out = n_out;
    for (int c = 0; c < 6; c++) begin
      drive_seq(n_in - b_in);
      step();
    end
    chk("bp_accepted", 160'(n_in - b_in), 160'(3));
    chk("bp_in_ready", 160'(bus.in_ready), 160'(0));
    bus.out_ready = 1'b1;
    cyc = 0;
    while (n_out - b_out < 5 && cyc < 12) begin
      if (n_in - b_in < 5) drive_seq(n_in - b_in);
      else bus.in_valid = 1'b0;
      step();
      cyc++;
    end
    chk("bp_drain_cycles", 160'(cyc), 160'(5));
    chk("bp_emitted", 160'(n_out - b_out), 160'(5));
    bus.in_valid = 1'b0;
    drive_seq(7);
    step();
    drive_seq(8);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", 160'(bus.out_valid), 160'(0));
    chk("rst_mid_m_o", 160'(bus.m_o), 160'(0));
    q.delete();
    pend_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_in_ready", 160'(bus.in_ready), 160'(1));
    @(negedge clk);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) seen++;
      step();
    end
    chk("rst_mid_no_emit", 160'(seen), 160'(0));
    b_in = n_in;
    b_out = n_out;
    cyc = 0;
    rand_beat();
    bus.in_valid = $urandom_range(0, 3) != 0;
    while (n_in - b_in < 10000 && cyc < 60000) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      k = n_in;
      step();
      cyc++;
      if (n_in != k || !bus.in_valid) begin
        rand_beat();
        bus.in_valid = $urandom_range(0, 3) != 0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rand_accepted", 160'(n_in - b_in), 160'(10000));
    chk("rand_emitted", 160'(n_out - b_out), 160'(10000));
    chk("rand_queue_empty", 160'(q.size()), 160'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/align_pipe.md
Name: align_pipe

Overview:
- Pipelined, back-pressurable successor to the combinational block aligner; sits between the FP operand unpack and the dot-product adder tree.
- Per beat it takes N floating-point lanes and finds the block max exponent. Each mantissa is right-shifted to that exponent with guard bits and a sticky bit, then converted to two's complement with log2(N) headroom bits.
- Adds zero/special handling, shift saturation, valid/ready flow control and a fixed 3-cycle latency.

Parameters:
- N, 16, lane count (power of two, >=2)
- E_WIDTH, 8, exponent width
- M_WIDTH, 23, stored mantissa width (hidden one excluded)
- GUARD_WIDTH, 3, extra LSBs below the mantissa; the bottom one is the sticky bit (>=2)
- X_WIDTH, clog2(N), headroom bits for the downstream adder tree
- OUT_W, 1+X_WIDTH+1+M_WIDTH+GUARD_WIDTH, per-lane output width (sign, headroom, hidden one, mantissa, guard)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- s_i  in  N  lane sign bits
- e_i  in  E_WIDTH*N  lane biased exponents, lane i at [i*E_WIDTH +: E_WIDTH]
- m_i  in  M_WIDTH*N  lane mantissas, same packing
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- e_o  out  E_WIDTH  block max exponent
- m_o  out  OUT_W*N  aligned two's-complement lanes
- special_o  out  1  some lane had an all-ones exponent (Inf/NaN)

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, on `reset`.
- Reset values: all stage valids 0, out_valid 0, e_o 0, m_o 0, special_o 0.
- Reset asserted mid-operation drops all in-flight beats. in_ready = 1 on the first cycle after reset deasserts.
- Pipeline: 3 stages, each with a valid bit.
  - S1 registers the inputs and the max exponent (tree).
  - S2 registers the shifted magnitude plus sticky.
  - S3 registers the negated result, the output register.
- Latency: exactly 3 cycles from the accepting edge to out_valid, when never stalled.
- Flow control:
  - A stage advances when its successor is empty or advancing. S3 advances on out_ready.
  - in_ready = !S1.valid || S1 advances. This is combinational from out_ready.
  - A transfer happens when valid && ready, on both sides.
  - With out_valid=1 and out_ready=0, all outputs hold stable.
  - Order is preserved, with no loss or duplication. A full pipe holds 3 beats.
  - Simultaneous accept and emit is allowed every cycle, giving 1 beat/cycle throughput.
- Zero lane (e=0): the hidden one is 0 and the mantissa is ignored. The lane outputs 0 regardless of sign. Denormals are flushed to zero.
- Special lane (e=all ones): excluded from the max. The lane outputs 0 and special_o=1 for that beat.
- Max exponent: the max over non-special lanes. If no lane qualifies, e_o=0 and all lanes are 0.
- Shift amount: d = e_o − e_i[lane] (unsigned).
  - Magnitude = {1'b(e!=0), m, GUARD_WIDTH'b0} >> d.
  - The sticky LSB is set to (that LSB) OR (any bit shifted out).
  - If d >= M_WIDTH+GUARD_WIDTH+1, the magnitude is 0 and sticky = hidden one (1 for nonzero lanes).
- Sign: if s=1, the output is the OUT_W-bit two's complement of the zero-extended magnitude; otherwise it is the magnitude. A negative zero-magnitude lane outputs 0.
- Arithmetic: all arithmetic is done at OUT_W bits; no overflow is possible.

Decomposition:
- Shared package align_pkg:
  - clog2 function
  - the OUT_W derivation
  - the lane slice helper
  - the EXP_SPECIAL constant (all ones)
- One natural sub-module: max_tree, a registered-free combinational max reduction over N exponents with a per-lane enable mask, instantiated in S1.

Test Plan:
- Basic alignment, N=4, G=3 (OUT_W=30): e={130,128,0,127}, s={0,1,0,0}, m=0, with the pipe empty beforehand.
  - Required after 3 cycles: out_valid=1 and e_o=130.
  - m_o lanes = {0x4000000, 0x3F000000, 0x0, 0x0800000}.
- Sticky and saturation:
  - Lane e=103 vs max 130 with m=1: d=27, so the lane outputs 0x1 (sticky only).
  - Lane e=1 vs max 255−1=254: saturates, so the lane outputs 0x1. If the same lane has s=1, the output is 0x3FFFFFFF.
- Specials: one lane e=255, the others e=100/90/0.
  - Required: special_o=1, e_o=100, the special lane 0, and the remaining lanes aligned to 100.
- Backpressure: push 5 consecutive beats with out_ready=0.
  - Required: 3 beats are accepted, then in_ready=0. Outputs stay stable.
  - After out_ready=1, all 5 beats emerge in order, one per cycle.
- Reset: assert reset for one cycle while 2 beats are in flight.
  - Required: out_valid=0 and m_o=0 on the next edge. Neither beat is ever emitted.
- Random: 10k beats with random valid/ready and random exponents/mantissas, checked against a golden model. The checker holds the ordering and stability rules.
